// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU type definitions.
//   word_t         : 32-bit machine word.
//   ICACHE_SETS    : default frame count of the instruction cache.
//   icache_addr_t  : fetch address split into tag / index / byte offset.
//   icache_frame_t : one direct-mapped frame (valid, tag, data).
//   icache_state_t : instruction cache controller states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icache_addr_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache.
// Hits are served combinationally in IDLE; a miss moves to FETCH, where the
// frame is filled from the memory controller instruction channel.
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   imemREN, imemaddr   datapath fetch request and byte address
//   flush               invalidate every frame
//   ihit, imemload      hit indication and instruction word to datapath
//   iREN, iaddr         fill request and word address to memory controller
//   iwait, iload        controller wait (low = iload valid) and fill data
//   hit_count           wrapping count of hit cycles since reset
//   miss_count          wrapping count of misses since reset
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  icache_state_t     state_r, state_next_s;
  logic [SETS-1:0]   valid_r;
  logic [TAG_W-1:0]  tag_r  [SETS];
  word_t             data_r [SETS];
  word_t             fill_addr_r;
  logic              flush_pend_r;
  logic [31:0]       hit_count_r, miss_count_r;

  logic [IDX_W-1:0]  look_idx_s, fill_idx_s;
  logic [TAG_W-1:0]  look_tag_s, fill_tag_s;
  logic              hit_s, miss_s, fill_done_s;

  assign look_idx_s = imemaddr[IDX_W+1:2];
  assign look_tag_s = imemaddr[31:IDX_W+2];
  assign fill_idx_s = fill_addr_r[IDX_W+1:2];
  assign fill_tag_s = fill_addr_r[31:IDX_W+2];

  // Lookup and miss detection; a flush cycle in IDLE neither hits nor misses.
  always_comb begin
    hit_s       = 1'b0;
    miss_s      = 1'b0;
    fill_done_s = 1'b0;
    if (state_r == IDLE && imemREN && !flush) begin
      hit_s  = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);
      miss_s = !hit_s;
    end else if (state_r == FETCH) begin
      // Only the first iwait-low cycle is captured: we leave FETCH right after.
      fill_done_s = !iwait;
    end else begin
      hit_s  = 1'b0;
      miss_s = 1'b0;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next_s = state_r;
    ihit         = 1'b0;
    imemload     = 32'd0;
    iREN         = 1'b0;
    iaddr        = 32'd0;
    case (state_r)
      IDLE: begin
        ihit     = hit_s;
        imemload = hit_s ? data_r[look_idx_s] : 32'd0;
        if (miss_s) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        // The controller cannot abort a started fetch, so the request is
        // held until data returns regardless of the datapath address.
        iREN  = 1'b1;
        iaddr = fill_addr_r;
        if (fill_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FETCH;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, fill address and performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      fill_addr_r  <= 32'd0;
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (hit_s) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (miss_s) begin
        miss_count_r <= miss_count_r + 32'd1;
        fill_addr_r  <= imemaddr & 32'hFFFF_FFFC;
      end
    end
  end

  // Valid bits and deferred flush. A flush seen during FETCH (including the
  // completion cycle) lets the fill finish but leaves every frame invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_r      <= '0;
      flush_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (flush) begin
            valid_r <= '0;
          end
        end
        FETCH: begin
          if (fill_done_s) begin
            if (flush_pend_r || flush) begin
              valid_r      <= '0;
              flush_pend_r <= 1'b0;
            end else begin
              valid_r[fill_idx_s] <= 1'b1;
            end
          end else if (flush) begin
            flush_pend_r <= 1'b1;
          end
        end
        default: begin
          valid_r      <= '0;
          flush_pend_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays are not reset; a reset during FETCH suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && fill_done_s) begin
      tag_r[fill_idx_s]  <= fill_tag_s;
      data_r[fill_idx_s] <= iload;
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache.
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked 1 time unit later, well away from the next edge.
module tb_icache;

  logic        CLK, RST, imemREN, flush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, hit_count, miss_count;

  int errors = 0;
  int checks = 0;

  icache dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .flush(flush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h0000_0040;
    flush = 1'b0; iwait = 1'b1; iload = 32'd0;
    tick; tick;
    RST = 1'b0;
  endtask

  // Miss on addr, then controller returns data on the first FETCH cycle.
  task automatic fill(input logic [31:0] addr, input logic [31:0] data);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    tick;
    imemREN = 1'b0; iwait = 1'b0; iload = data;
    tick;
    iwait = 1'b1; iload = 32'd0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got=%0h exp=0", ihit); end
    checks++; if (imemload !== 32'd0) begin errors++; $display("FAIL reset_imemload got=%08h exp=0", imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN got=%0h exp=0", iREN); end
    checks++; if (iaddr !== 32'd0) begin errors++; $display("FAIL reset_iaddr got=%08h exp=0", iaddr); end
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    imemREN = 1'b0;
  endtask

  task automatic test_basic;
    do_reset;
    imemREN = 1'b1; imemaddr = 32'h0000_0040; #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL basic_first_miss got=%0h exp=0", ihit); end
    tick; #1;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h0000_0040) begin errors++; $display("FAIL basic_fetch_req got=%0h/%08h exp=1/00000040", iREN, iaddr); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL basic_fetch_ihit got=%0h exp=0", ihit); end
    tick; tick;
    iwait = 1'b0; iload = 32'h2001_0005;
    tick;
    iwait = 1'b1; iload = 32'd0; #1;
    checks++; if (iREN !== 1'b0 || iaddr !== 32'd0) begin errors++; $display("FAIL basic_iren_drop got=%0h/%08h exp=0/0", iREN, iaddr); end
    checks++; if (ihit !== 1'b1 || imemload !== 32'h2001_0005) begin errors++; $display("FAIL basic_hit got=%0h/%08h exp=1/20010005", ihit, imemload); end
    tick;
    imemREN = 1'b0; #1;
    checks++; if (miss_count !== 32'd1 || hit_count !== 32'd1) begin errors++; $display("FAIL basic_counts got=%0d/%0d exp=1/1", miss_count, hit_count); end
  endtask

  task automatic test_conflict;
    do_reset;
    fill(32'h0000_0040, 32'hAAAA_0040);
    imemREN = 1'b1; imemaddr = 32'h0000_0440; #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conflict_second_miss got=%0h exp=0", ihit); end
    fill(32'h0000_0440, 32'hBBBB_0440);
    imemREN = 1'b1; imemaddr = 32'h0000_0440; #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hBBBB_0440) begin errors++; $display("FAIL conflict_new_hit got=%0h/%08h exp=1/bbbb0440", ihit, imemload); end
    tick;
    imemaddr = 32'h0000_0040; #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conflict_evicted got=%0h exp=0", ihit); end
    fill(32'h0000_0040, 32'hAAAA_0040);
    #1;
    checks++; if (miss_count !== 32'd3 || hit_count !== 32'd1) begin errors++; $display("FAIL conflict_counts got=%0d/%0d exp=3/1", miss_count, hit_count); end
  endtask

  task automatic test_addr_change;
    do_reset;
    imemREN = 1'b1; imemaddr = 32'h0000_0080;
    tick;
    imemaddr = 32'h0000_0100; #1;
    checks++; if (iaddr !== 32'h0000_0080 || ihit !== 1'b0) begin errors++; $display("FAIL addrchg_hold1 got=%08h/%0h exp=00000080/0", iaddr, ihit); end
    tick; #1;
    checks++; if (iaddr !== 32'h0000_0080 || iREN !== 1'b1) begin errors++; $display("FAIL addrchg_hold2 got=%08h/%0h exp=00000080/1", iaddr, iREN); end
    iwait = 1'b0; iload = 32'hD000_0080;
    tick;
    iwait = 1'b1; iload = 32'd0;
    imemaddr = 32'h0000_0080; #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hD000_0080) begin errors++; $display("FAIL addrchg_first_data got=%0h/%08h exp=1/d0000080", ihit, imemload); end
    tick;
    imemaddr = 32'h0000_0100; #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL addrchg_second_miss got=%0h exp=0", ihit); end
    tick; #1;
    checks++; if (iaddr !== 32'h0000_0100 || iREN !== 1'b1) begin errors++; $display("FAIL addrchg_second_req got=%08h/%0h exp=00000100/1", iaddr, iREN); end
    iwait = 1'b0; iload = 32'hD000_0100;
    tick;
    iwait = 1'b1; iload = 32'd0; #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hD000_0100) begin errors++; $display("FAIL addrchg_second_data got=%0h/%08h exp=1/d0000100", ihit, imemload); end
    tick;
    imemREN = 1'b0; #1;
    checks++; if (miss_count !== 32'd2 || hit_count !== 32'd2) begin errors++; $display("FAIL addrchg_counts got=%0d/%0d exp=2/2", miss_count, hit_count); end
  endtask

  task automatic test_iwait_hold;
    do_reset;
    imemREN = 1'b1; imemaddr = 32'h0000_0040;
    tick;
    imemREN = 1'b0; iwait = 1'b0; iload = 32'h1111_1111;
    tick;
    iload = 32'h2222_2222; #1;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL hold_iren_low got=%0h exp=0", iREN); end
    tick;
    iwait = 1'b1; iload = 32'd0;
    imemREN = 1'b1; #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'h1111_1111) begin errors++; $display("FAIL hold_first_sample got=%0h/%08h exp=1/11111111", ihit, imemload); end
    tick;
    imemREN = 1'b0; #1;
    checks++; if (miss_count !== 32'd1 || hit_count !== 32'd1) begin errors++; $display("FAIL hold_counts got=%0d/%0d exp=1/1", miss_count, hit_count); end
  endtask

  task automatic test_flush_idle;
    logic [31:0] addrs [4];
    addrs[0] = 32'h0000_0040; addrs[1] = 32'h0000_0044;
    addrs[2] = 32'h0000_0048; addrs[3] = 32'h0000_004C;
    do_reset;
    for (int i = 0; i < 4; i++) fill(addrs[i], 32'hF000_0000 + 32'(i));
    imemREN = 1'b1; imemaddr = addrs[2]; #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hF000_0002) begin errors++; $display("FAIL flush_prefill_hit got=%0h/%08h exp=1/f0000002", ihit, imemload); end
    flush = 1'b1; #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flush_force_miss got=%0h exp=0", ihit); end
    tick;
    flush = 1'b0; imemREN = 1'b0; #1;
    checks++; if (iREN !== 1'b0 || miss_count !== 32'd4) begin errors++; $display("FAIL flush_no_miss got=%0h/%0d exp=0/4", iREN, miss_count); end
    for (int i = 0; i < 4; i++) begin
      imemREN = 1'b1; imemaddr = addrs[i]; #1;
      checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flush_invalid_%0d got=%0h exp=0", i, ihit); end
      imemREN = 1'b0;
    end
  endtask

  task automatic test_flush_fetch;
    do_reset;
    imemREN = 1'b1; imemaddr = 32'h0000_00C0;
    tick;
    imemREN = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0; #1;
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h0000_00C0) begin errors++; $display("FAIL flushf_fill_continues got=%0h/%08h exp=1/000000c0", iREN, iaddr); end
    iwait = 1'b0; iload = 32'hCCCC_00C0;
    tick;
    iwait = 1'b1; iload = 32'd0;
    imemREN = 1'b1; #1;
    checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("FAIL flushf_lookup_miss got=%0h/%0h exp=0/0", ihit, iREN); end
    imemREN = 1'b0;
  endtask

  task automatic test_reset_mid_fetch;
    do_reset;
    fill(32'h0000_0040, 32'h4444_0040);
    imemREN = 1'b1; imemaddr = 32'h0000_0080;
    tick;
    RST = 1'b1; imemREN = 1'b0; iwait = 1'b0; iload = 32'h8888_0080;
    tick;
    RST = 1'b0; iwait = 1'b1; iload = 32'd0; #1;
    checks++; if (iREN !== 1'b0 || iaddr !== 32'd0) begin errors++; $display("FAIL rstfetch_iren got=%0h/%08h exp=0/0", iREN, iaddr); end
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rstfetch_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    imemREN = 1'b1; imemaddr = 32'h0000_0040; #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rstfetch_old_frame got=%0h exp=0", ihit); end
    imemaddr = 32'h0000_0080; #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rstfetch_aborted_frame got=%0h exp=0", ihit); end
    imemREN = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_conflict;
    test_addr_change;
    test_iwait_hold;
    test_flush_idle;
    test_flush_fetch;
    test_reset_mid_fetch;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
